muldiv_unit: RTL and testbench

Iterative unsigned multiply/divide unit in the EX stage of the pipelined CPU. Accepts two operands on a start pulse, runs a shift-add multiply or restoring divide over N+1 cycles, and presents a registered result with a one-cycle done pulse. Its result is one input of the EX result mux2; the ALU output is the other, and the hazard unit stalls the pipeline while busy is high.

---
 rtl/muldiv_unit_if.sv | 24 ++
 rtl/muldiv_unit.sv | 81 ++++++++
 tb/tb_muldiv_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
// Purely combinational wiring; the master drives requests and the slave returns status/result.
interface muldiv_unit_if #(
   parameter int N = 31
);
   logic         start;
   logic         flush;
   logic [1:0]   op;
   logic [N:0]   a;
   logic [N:0]   b;
   logic         busy;
   logic         done;
   logic [N:0]   result;

   modport master (
      output start, flush, op, a, b,
      input  busy, done, result
   );

   modport slave (
      input  start, flush, op, a, b,
      output busy, done, result
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned shift-add multiply / restoring divide; done pulses W edges after the accepting start (divide-by-zero: next edge).
// No backpressure or queuing: start is honoured only in IDLE, busy stalls the pipeline, flush aborts from any state.
module muldiv_unit #(
   parameter int N = 31
) (
   input  logic         clk,
   input  logic         rst_n,
   muldiv_unit_if.slave bus
);
   localparam int W  = N + 1;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(N);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [1:0]      op_q;
   logic [N:0]      opnd;
   logic [2*W-1:0]  acc, acc_nxt;
   logic [N:0]      res_q, res_sel;
   logic [W:0]      mul_sum, div_rem, div_diff;
   logic            accept, div_zero;

   assign accept   = (state == IDLE) && bus.start && !bus.flush;
   assign div_zero = bus.op[1] && (bus.b == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = div_zero ? DONE : RUN;
         RUN:     if (cnt == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.flush) state_nxt = IDLE;
   end

   // Multiply: acc = {partial product, remaining multiplier}; divide: acc = {remainder, dividend->quotient}.
   always_comb begin
      mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
      div_rem  = acc[2*W-1:W-1];
      div_diff = div_rem - {1'b0, opnd};
      if (op_q[1]) begin
         if (div_diff[W]) acc_nxt = {div_rem[W-1:0], acc[W-2:0], 1'b0};
         else             acc_nxt = {div_diff[W-1:0], acc[W-2:0], 1'b1};
      end else begin
         acc_nxt = {mul_sum, acc[W-1:1]};
      end
      res_sel = op_q[0] ? acc_nxt[2*W-1:W] : acc_nxt[W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         op_q  <= '0;
         opnd  <= '0;
         acc   <= '0;
         res_q <= '0;
      end else if (accept) begin
         cnt  <= '0;
         op_q <= bus.op;
         opnd <= bus.op[1] ? bus.b : bus.a;
         acc  <= bus.op[1] ? {{W{1'b0}}, bus.a} : {{W{1'b0}}, bus.b};
         if (div_zero) res_q <= bus.op[0] ? bus.a : '1;
      end else if (state == RUN && !bus.flush) begin
         acc <= acc_nxt;
         cnt <= cnt + CW'(1);
         if (cnt == LAST) res_q <= res_sel;
      end
   end

   assign bus.busy   = (state == RUN);
   assign bus.done   = (state == DONE);
   assign bus.result = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, randomized ops against an arithmetic model, and
// hand-written reset / start-while-busy / start-during-done / flush sequences.
module tb_muldiv_unit;
   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   muldiv_unit_if #(.N(31)) bus ();
   muldiv_unit #(.N(31)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = {32'b0, a} * {32'b0, b};
      case (op)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issues one operation and waits (bounded) for done; checks latency, result, busy and done behaviour.
   task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat);
      int k;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      tick();
      bus.start = 1'b0;
      bus.op    = 2'($urandom_range(0, 3));
      bus.a     = $urandom;
      bus.b     = $urandom;
      check({nm, " busy_after_start"}, bus.busy, (exp_lat != 0));
      k = 0;
      while (!bus.done && k < 100) begin
         tick();
         k++;
         check({nm, " busy_done_excl"}, bus.busy & bus.done, 1'b0);
      end
      check({nm, " latency"}, k, exp_lat);
      check({nm, " result"}, bus.result, exp_res);
      check({nm, " busy_at_done"}, bus.busy, 1'b0);
      tick();
      check({nm, " done_single"}, bus.done, 1'b0);
      check({nm, " result_hold"}, bus.result, exp_res);
   endtask

   task automatic watch(input int cycles, output int dones, output logic [31:0] last_res);
      dones    = 0;
      last_res = bus.result;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (bus.done) begin
            dones++;
            last_res = bus.result;
         end
      end
   endtask

   initial begin
      int          dones;
      logic [31:0] r;
      logic [1:0]  op;
      logic [31:0] a, b;
      int          k;

      vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32};
      vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
      vecs[2]  = '{2'b10, 32'd100,       32'd7,         32'd14,        32};
      vecs[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32};
      vecs[4]  = '{2'b10, 32'd5,         32'd9,         32'd0,         32};
      vecs[5]  = '{2'b11, 32'd5,         32'd9,         32'd5,         32};
      vecs[6]  = '{2'b10, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 0};
      vecs[7]  = '{2'b11, 32'h0000_1234, 32'd0,         32'h0000_1234, 0};
      vecs[8]  = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32};
      vecs[9]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32};
      vecs[10] = '{2'b00, 32'h0000_1234, 32'd0,         32'h0000_0000, 32};
      vecs[11] = '{2'b10, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32};

      rst_n     = 1'b1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      #2 rst_n = 1'b0;
      tick();
      tick();
      check("reset_busy", bus.busy, 1'b0);
      check("reset_done", bus.done, 1'b0);
      check("reset_result", bus.result, 32'h0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 12; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         k  = $urandom_range(0, 7);
         b  = (k == 0) ? 32'd0 : (k < 4) ? 32'($urandom_range(1, 300)) : $urandom;
         run_op($sformatf("rnd%0d", i), op, a, b, model(op, a, b), (op[1] && b == 0) ? 0 : 32);
      end

      // Reset in the middle of a multiply: immediate abort, no late done.
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'hFFFF; bus.b = 32'hFFFF;
      tick();
      bus.start = 1'b0;
      repeat (9) tick();
      rst_n = 1'b0;
      #1;
      check("midrun_reset_busy", bus.busy, 1'b0);
      check("midrun_reset_done", bus.done, 1'b0);
      check("midrun_reset_result", bus.result, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      watch(40, dones, r);
      check("midrun_reset_no_done", dones, 0);
      check("midrun_reset_busy_after", bus.busy, 1'b0);

      // A second start at cycle 10 of a multiply is dropped.
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd5;
      tick();
      bus.start = 1'b0;
      repeat (9) tick();
      bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd7; bus.b = 32'd7;
      tick();
      bus.start = 1'b0;
      watch(60, dones, r);
      check("busy_start_dones", dones, 1);
      check("busy_start_result", r, 32'd15);
      check("busy_start_held", bus.result, 32'd15);

      // A start presented while done is high is also dropped.
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd3;
      tick();
      bus.start = 1'b0;
      k = 0;
      while (!bus.done && k < 100) begin
         tick();
         k++;
      end
      check("done_start_lat", k, 32);
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd9;
      tick();
      bus.start = 1'b0;
      check("done_start_busy", bus.busy, 1'b0);
      watch(40, dones, r);
      check("done_start_no_done", dones, 0);
      check("done_start_result", bus.result, 32'd6);

      // Flush at cycle 15 of a divide, with start asserted on the same edge.
      bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd3;
      tick();
      bus.start = 1'b0;
      repeat (14) tick();
      bus.flush = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd4; bus.b = 32'd4;
      tick();
      bus.flush = 1'b0; bus.start = 1'b0;
      check("flush_busy", bus.busy, 1'b0);
      check("flush_done", bus.done, 1'b0);
      check("flush_result", bus.result, 32'd6);
      watch(40, dones, r);
      check("flush_no_done", dones, 0);
      check("flush_result_held", bus.result, 32'd6);
      run_op("post_flush", 2'b10, 32'd1000, 32'd3, 32'd333, 32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
